// File: rtl/servo_pkg.sv
// Shared constants, types and helpers for the hobby-servo PWM generator.
// Defaults assume a 12 MHz clock and a 20 ms frame.
package servo_pkg;

  localparam int unsigned ANGLE_W   = 8;
  localparam int unsigned ANGLE_MAX = 180;

  localparam int unsigned DEF_PERIOD_TICKS = 240000;
  localparam int unsigned DEF_MIN_TICKS    = 6000;
  localparam int unsigned DEF_DEG_TICKS    = 133;
  localparam int unsigned DEF_STEP_DEG     = 2;

  typedef logic [ANGLE_W-1:0] angle_t;

  // Commands above full travel are pinned to full travel.
  function automatic angle_t clamp_angle(input angle_t a);
    return (a > angle_t'(ANGLE_MAX)) ? angle_t'(ANGLE_MAX) : a;
  endfunction

endpackage

// File: rtl/servo_slew.sv
// Per-frame slew limiter: holds the target and the angle actually output.
// Ports: clk, rst_n, i_load (stage A strobe), i_target (clamped angle),
//        o_cur_angle (angle being output), o_at_target (cur == target).
module servo_slew
  import servo_pkg::*;
#(
  parameter bit          SLEW_EN   = 1'b1,
  parameter int unsigned STEP_DEG  = DEF_STEP_DEG,
  parameter int unsigned RST_ANGLE = 0
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   i_load,
  input  angle_t i_target,
  output angle_t o_cur_angle,
  output logic   o_at_target
);

  localparam angle_t STEP  = angle_t'(STEP_DEG);
  localparam angle_t RST_A = angle_t'(RST_ANGLE);

  angle_t r_target;
  angle_t r_cur;
  angle_t w_next;

  // Move at most STEP toward the target; the final step lands exactly.
  always_comb begin
    w_next = i_target;
    if (SLEW_EN) begin
      if (i_target > r_cur) begin
        if ((i_target - r_cur) > STEP) begin
          w_next = r_cur + STEP;
        end
      end else if ((r_cur - i_target) > STEP) begin
        w_next = r_cur - STEP;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_target <= RST_A;
      r_cur    <= RST_A;
    end else if (i_load) begin
      r_target <= i_target;
      r_cur    <= w_next;
    end
  end

  assign o_cur_angle = r_cur;
  assign o_at_target = (r_cur == r_target);

endmodule

// File: rtl/servo_pwm_gen.sv
// Hobby-servo PWM generator: fixed frame, pulse width linear in angle.
// Ports: clk, rst_n, angle_in, enable -> pwm_out, period_start,
//        cur_angle, at_target.
module servo_pwm_gen
  import servo_pkg::*;
#(
  parameter int unsigned PERIOD_TICKS = DEF_PERIOD_TICKS,
  parameter int unsigned MIN_TICKS    = DEF_MIN_TICKS,
  parameter int unsigned DEG_TICKS    = DEF_DEG_TICKS,
  parameter bit          SLEW_EN      = 1'b1,
  parameter int unsigned STEP_DEG     = DEF_STEP_DEG,
  parameter int unsigned RST_ANGLE    = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [ANGLE_W-1:0] angle_in,
  input  logic               enable,
  output logic               pwm_out,
  output logic               period_start,
  output logic [ANGLE_W-1:0] cur_angle,
  output logic               at_target
);

  localparam int unsigned CNT_W = $clog2(PERIOD_TICKS);
  typedef logic [CNT_W-1:0] cnt_t;

  localparam cnt_t LAST    = cnt_t'(PERIOD_TICKS - 1);
  localparam cnt_t STAGE_A = cnt_t'(PERIOD_TICKS - 2);
  localparam cnt_t MIN_W   = cnt_t'(MIN_TICKS);
  localparam cnt_t DEG_W   = cnt_t'(DEG_TICKS);
  localparam cnt_t RST_W   = cnt_t'(MIN_TICKS + RST_ANGLE * DEG_TICKS);

  localparam bit LEGAL =
    (PERIOD_TICKS > MIN_TICKS + ANGLE_MAX * DEG_TICKS + 2) &&
    (STEP_DEG >= 1) && (RST_ANGLE <= ANGLE_MAX);

  cnt_t   r_cnt;
  cnt_t   r_width;
  logic   r_en_lat;
  logic   r_pwm;
  logic   r_ps;
  logic   w_stage_a;
  logic   w_stage_b;
  angle_t w_clamped;
  angle_t w_cur;
  cnt_t   w_width;

  assign w_stage_a = (r_cnt == STAGE_A);
  assign w_stage_b = (r_cnt == LAST);
  assign w_clamped = clamp_angle(angle_in);
  assign w_width   = MIN_W + cnt_t'(w_cur) * DEG_W;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_stage_b) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Stage A (slew) runs one clock ahead of stage B so the width
  // latched at the frame end already reflects the new angle.
  servo_slew #(
    .SLEW_EN   (SLEW_EN),
    .STEP_DEG  (STEP_DEG),
    .RST_ANGLE (RST_ANGLE)
  ) u_slew (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_load      (w_stage_a),
    .i_target    (w_clamped),
    .o_cur_angle (w_cur),
    .o_at_target (at_target)
  );

  // Width and enable change only at the frame boundary: no runts.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_width  <= RST_W;
      r_en_lat <= 1'b0;
    end else if (w_stage_b) begin
      r_width  <= w_width;
      r_en_lat <= enable;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pwm <= 1'b0;
      r_ps  <= 1'b0;
    end else begin
      r_pwm <= r_en_lat & (r_cnt < r_width);
      r_ps  <= (r_cnt == '0);
    end
  end

  assign pwm_out      = r_pwm;
  assign period_start = r_ps;
  assign cur_angle    = w_cur;

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    assert (LEGAL)
      else $error("servo_pwm_gen: illegal parameter set");
  end
`endif

endmodule
